// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: sequential shift-and-add multiplier, one partial product per clock.
// Define MULT_SIGNED_EN for two's-complement operands (final partial product subtracted).
module seq_shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               ready,
   output logic               busy,
   output logic [2*WIDTH-1:0] product,
   output logic               valid,
   input  logic               ack
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] m, q;
   logic [PW-1:0] acc, m_ext, pp, acc_nxt;
   logic [CNT_W-1:0] k;
   logic last;
   always_comb begin
      last = k == CNT_W'(WIDTH - 1);
`ifdef MULT_SIGNED_EN
      m_ext = {{WIDTH{m[WIDTH-1]}}, m};
      pp = q[k] ? m_ext << k : '0;
      // the sign bit of Q carries negative weight
      acc_nxt = last ? acc - pp : acc + pp;
`else
      m_ext = {{WIDTH{1'b0}}, m};
      pp = q[k] ? m_ext << k : '0;
      acc_nxt = acc + pp;
`endif
   end
   always_comb begin
      ready = state == IDLE;
      busy = state == BUSY;
      valid = state == DONE;
      state_nxt = (state == IDLE && start) ? BUSY :
                  (state == BUSY && last)  ? DONE :
                  (state == DONE && ack)   ? IDLE : state;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         m <= '0;
         q <= '0;
         acc <= '0;
         k <= '0;
         product <= '0;
      end else if (state == IDLE && start) begin
         m <= multiplicand;
         q <= multiplier;
         acc <= '0;
         k <= '0;
      end else if (state == BUSY) begin
         acc <= acc_nxt;
         k <= last ? '0 : k + CNT_W'(1);
         if (last) product <= acc_nxt;
      end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed and random multiplies against an arithmetic reference.
module tb_seq_shift_add_multiplier;
   localparam int W = 4;
   logic clock = 0, reset = 1, start = 0, ack = 0;
   logic [W-1:0] multiplicand = '0, multiplier = '0;
   logic ready, busy, valid;
   logic [2*W-1:0] product;
   int checks = 0, failures = 0;

   seq_shift_add_multiplier #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .ready(ready), .busy(busy), .product(product), .valid(valid), .ack(ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
      return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
`else
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
   endfunction

   task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [2*W-1:0] exp;
      exp = ref_mul(a, b);
      check("idle_ready", ready, 1);
      multiplicand = a;
      multiplier = b;
      start = 1;
      ack = 0;
      tick();
      for (int i = 1; i < W; i++) begin
         check("busy", busy, 1);
         check("busy_ready_valid", {ready, valid}, 0);
         multiplicand = W'($urandom);
         multiplier = W'($urandom);
         start = 1'($urandom);
         ack = 1'($urandom);
         tick();
      end
      check("busy_last", busy, 1);
      ack = 0;
      start = 0;
      tick();
      check("valid_latency", valid, 1);
      check("product", product, exp);
      for (int i = 0; i < hold; i++) begin
         start = 1'($urandom);
         multiplicand = W'($urandom);
         tick();
         check("hold_valid", {valid, ready, busy}, 3'b100);
         check("hold_product", product, exp);
      end
      ack = 1;
      start = 1;
      tick();
      check("ack_idle", {ready, busy, valid}, 3'b100);
      check("product_kept", product, exp);
      ack = 0;
      start = 0;
   endtask

   initial begin
      logic [W-1:0] dm [5] = '{4'hB, 4'h0, 4'hF, 4'h1, 4'h6};
      logic [W-1:0] dq [5] = '{4'hD, 4'hF, 4'hF, 4'h8, 4'h7};
      logic [W-1:0] sm [4] = '{4'hF, 4'h8, 4'h8, 4'h3};
      logic [W-1:0] sq [4] = '{4'hF, 4'h8, 4'h7, 4'hE};
      repeat (2) @(posedge clock);
      #1;
      check("rst_flags", {ready, busy, valid}, 3'b100);
      check("rst_product", product, 0);
      reset = 0;
      tick();
      check("idle_after_rst", {ready, busy, valid}, 3'b100);
      for (int i = 0; i < 5; i++) do_mult(dm[i], dq[i], 1);
      for (int i = 0; i < 4; i++) do_mult(sm[i], sq[i], 0);
      do_mult(4'h6, 4'h7, 10);
      multiplicand = 4'h9;
      multiplier = 4'h5;
      start = 1;
      tick();
      start = 0;
      tick();
      #2 reset = 1;
      #1;
      check("async_rst_flags", {ready, busy, valid}, 3'b100);
      check("async_rst_product", product, 0);
      @(negedge clock);
      reset = 0;
      tick();
      check("post_rst_idle", {ready, busy, valid}, 3'b100);
      do_mult(4'hB, 4'hD, 2);
      for (int i = 0; i < 60; i++)
         do_mult(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
